instruction_decoder: RTL

//  Consumes the 8-bit word from the program ROM, registers it into the instruction

---
 rtl/instruction_decoder_if.sv | 36 +++
 rtl/instruction_decoder.sv | 107 ++++++++++
 2 files changed

// File: rtl/instruction_decoder_if.sv
// Bundle between the instruction decoder, the program ROM, the ALU and the sequencer/datapath.
// Latency: none. These are plain wires.
// Backpressure: none. The decoder consumes one ROM word on every clock.
//
// Ports (master = decoder side):
//   pm_data, alu_zero                  : inputs to the decoder
//   sync_reset, ir, jmp, jmp_nz, jmp_addr,
//   dont_jmp, reg_ld, src_sel, imm,
//   alu_en, alu_func                   : decoder outputs
interface instruction_decoder_if;
    logic [7:0] pm_data;
    logic       alu_zero;
    logic       sync_reset;
    logic [7:0] ir;
    logic       jmp;
    logic       jmp_nz;
    logic [3:0] jmp_addr;
    logic       dont_jmp;
    logic [3:0] reg_ld;
    logic [2:0] src_sel;
    logic [3:0] imm;
    logic       alu_en;
    logic [3:0] alu_func;

    modport master (
        input  pm_data, alu_zero,
        output sync_reset, ir, jmp, jmp_nz, jmp_addr, dont_jmp,
               reg_ld, src_sel, imm, alu_en, alu_func
    );

    modport slave (
        output pm_data, alu_zero,
        input  sync_reset, ir, jmp, jmp_nz, jmp_addr, dont_jmp,
               reg_ld, src_sel, imm, alu_en, alu_func
    );
endinterface

// File: rtl/instruction_decoder.sv
// Registers the ROM word into the IR and decodes it. Also holds the zero flag and the synchronised sequencer reset.
// Latency: pm_data to ir is 1 cycle. Decode is combinational from ir. sync_reset deasserts RST_STAGES edges after reset_n rises.
// Backpressure: none. A new instruction is accepted every cycle.
//
// Ports: clk, reset_n (async, active-low) and dec (instruction_decoder_if.master):
//   in  pm_data[7:0], alu_zero
//   out sync_reset, ir[7:0], jmp, jmp_nz, jmp_addr[3:0], dont_jmp,
//       reg_ld[3:0], src_sel[2:0], imm[3:0], alu_en, alu_func[3:0]
module instruction_decoder #(
    parameter int         RST_STAGES = 2,
    parameter logic [7:0] NOP_WORD   = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instruction_decoder_if.master dec
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_MOV  = 2'b01,
        OP_ALU  = 2'b10,
        OP_JMP  = 2'b11
    } opcode_e;

    logic [RST_STAGES-1:0] rst_sr;
    logic                  sync_reset;
    logic [7:0]            ir_q;
    logic                  dont_jmp_q;

    opcode_e    opcode;
    logic [1:0] dst;
    logic [3:0] reg_ld;
    logic       alu_en;
    logic       jmp;
    logic       jmp_nz;

    // The shift register is filled with ones while reset is asserted.
    // Zeros are then shifted in, so the last stage falls on the RST_STAGES-th edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sr <= '1;
        end else begin
            rst_sr <= {rst_sr[RST_STAGES-2:0], 1'b0};
        end
    end

    assign sync_reset = rst_sr[RST_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q <= NOP_WORD;
        end else if (sync_reset) begin
            ir_q <= NOP_WORD;
        end else begin
            ir_q <= dec.pm_data;
        end
    end

    // The flag is written only by an ALU instruction.
    // A mid-run sync_reset leaves the flag untouched; only reset_n clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dont_jmp_q <= 1'b0;
        end else if (alu_en && !sync_reset) begin
            dont_jmp_q <= dec.alu_zero;
        end
    end

    assign opcode = opcode_e'(ir_q[7:6]);
    assign dst    = ir_q[5:4];

    always_comb begin
        reg_ld = 4'b0000;
        alu_en = 1'b0;
        jmp    = 1'b0;
        jmp_nz = 1'b0;
        case (opcode)
            OP_LOAD: reg_ld = 4'b0001 << dst;
            // A move from a register to itself is treated as a NOP.
            // ir[3] plays no part in this decision.
            OP_MOV: begin
                if (ir_q[2:0] != {1'b0, dst}) begin
                    reg_ld = 4'b0001 << dst;
                end
            end
            OP_ALU: alu_en = 1'b1;
            OP_JMP: begin
                jmp    = (dst == 2'b00);
                jmp_nz = (dst == 2'b01);
            end
            default: ;
        endcase
    end

    assign dec.sync_reset = sync_reset;
    assign dec.ir         = ir_q;
    assign dec.jmp        = jmp;
    assign dec.jmp_nz     = jmp_nz;
    assign dec.jmp_addr   = ir_q[3:0];
    assign dec.dont_jmp   = dont_jmp_q;
    assign dec.reg_ld     = reg_ld;
    assign dec.src_sel    = ir_q[2:0];
    assign dec.imm        = ir_q[3:0];
    assign dec.alu_en     = alu_en;
    assign dec.alu_func   = ir_q[3:0];

endmodule
